// File: rtl/vga_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : vga_arb_pkg                                                 |
// | Purpose  : Shared owner encodings and read latency for the VGA ROM     |
// |            arbiter and its owner-tag delay line.                       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package vga_arb_pkg;

  // Who owns the ROM port in a given selection cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Selection cycle to valid cycle: address reg, ROM access, data reg
  localparam int ARB_LAT = 3;

endpackage
`default_nettype wire

// File: rtl/vga_arb_tag_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vga_arb_tag_pipe                                            |
// | Purpose  : Delays the 2-bit owner tag by DEPTH cycles so it lines up   |
// |            with the registered ROM data; cleared synchronously.        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module vga_arb_tag_pipe
  import vga_arb_pkg::*;
#(
  parameter int DEPTH = ARB_LAT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  logic [1:0] stage [DEPTH];

  // Shift register; a reset drops every tag in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= 2'd0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vga_rom_arbiter                                             |
// | Purpose  : Shares one synchronous single-port ROM between a display    |
// |            fetcher (strict priority) and a host reader. Data returns   |
// |            three cycles after the selection cycle.                     |
// | Options  : VGA_ARB_STARVE_EN - host wait counter; after STARVE_MAX     |
// |            waiting cycles the host wins one cycle and disp_miss pulses.|
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module vga_rom_arbiter
  import vga_arb_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 15
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data
);

  owner_e            sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              host_done;   // granted, waiting for host_req to drop
  logic              host_pend;
  logic              force_host;
  logic [1:0]        tag_out;

  assign host_pend = host_req & ~host_done;

`ifdef VGA_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign force_host = host_pend & (wait_cnt == CNT_W'(STARVE_MAX));
  assign disp_miss  = rst_n & force_host & disp_req;

  // Count cycles a pending host request is left waiting; saturates at the limit
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (host_gnt || !host_req) begin
      wait_cnt <= '0;
    end else if (host_pend && (wait_cnt != CNT_W'(STARVE_MAX))) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  // STARVE_MAX only matters when the wait counter is built
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign force_host        = 1'b0;
  assign disp_miss         = 1'b0;
`endif

  // Owner selection: starvation override, then display, then host
  always_comb begin
    sel      = OWN_NONE;
    sel_addr = '0;
    if (force_host) begin
      sel      = OWN_HOST;
      sel_addr = host_addr;
    end else if (disp_req) begin
      sel      = OWN_DISP;
      sel_addr = disp_addr;
    end else if (host_pend) begin
      sel      = OWN_HOST;
      sel_addr = host_addr;
    end
  end

  assign host_gnt = rst_n & (sel == OWN_HOST);

  // Remember a grant until host_req is seen low, so a held request is served once
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      host_done <= 1'b0;
    end else if (host_gnt) begin
      host_done <= 1'b1;
    end else if (!host_req) begin
      host_done <= 1'b0;
    end
  end

  // ROM address register; holds when nobody owns the port
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (sel != OWN_NONE) begin
      rom_addr <= sel_addr;
    end
  end

  // Capture ROM output one cycle after it appears
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rom_data;
    end
  end

  vga_arb_tag_pipe #(
    .DEPTH (ARB_LAT)
  ) u_tag_pipe (
    .clk     (vga_clk),
    .rst_n   (rst_n),
    .tag_in  (sel),
    .tag_out (tag_out)
  );

  assign disp_valid = (tag_out == OWN_DISP);
  assign host_valid = (tag_out == OWN_HOST);

endmodule
`default_nettype wire
